// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - RAW hazard detection, EXE forwarding, branch flush and load/MDU stall FSM
// Optional stall-cycle performance counter built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int LOAD_LAT = 1,
    parameter int NUM_FWD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode_ID,
    input  logic [31:0] instrCode_EXE,
    input  logic [31:0] instrCode_MEM,
    input  logic [31:0] instrCode_WB,
    input  logic        regFileWe_MEM,
    input  logic        regFileWe_WB,
    input  logic        PC_SrcMuxSel,
    input  logic        mdu_start,
    input  logic        mdu_done,
    output logic [1:0]  Forward1,
    output logic [1:0]  Forward2,
    output logic        PCEn,
    output logic        stall,
    output logic        hold_EXE,
    output logic        bubble_EXE,
    output logic        flush_IF,
    output logic        flush_ID,
    output logic [1:0]  hz_state,
    output logic [31:0] stall_cycles
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Counter preload: the detect cycle is spent in IDLE, the last in LOAD_STALL with cnt == 0.
    localparam logic [2:0] CNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        MDU_BUSY   = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    function automatic logic rs1_used(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] op);
        return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic prod_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    logic [6:0] op_id, op_ex;
    logic [4:0] rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;
    logic       ld_use;
    logic       unused_bits;

    assign op_id  = instrCode_ID[6:0];
    assign rs1_id = instrCode_ID[19:15];
    assign rs2_id = instrCode_ID[24:20];
    assign op_ex  = instrCode_EXE[6:0];
    assign rd_ex  = instrCode_EXE[11:7];
    assign rs1_ex = instrCode_EXE[19:15];
    assign rs2_ex = instrCode_EXE[24:20];
    assign rd_mem = instrCode_MEM[11:7];
    assign rd_wb  = instrCode_WB[11:7];

    assign unused_bits = ^{instrCode_ID[31:25], instrCode_ID[14:7], instrCode_EXE[31:25],
                           instrCode_EXE[14:12], instrCode_MEM[31:12], instrCode_MEM[6:0],
                           instrCode_WB[31:12], instrCode_WB[6:0]};

    assign ld_use = (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((rs1_used(op_id) && (rs1_id == rd_ex)) ||
                     (rs2_used(op_id) && (rs2_id == rd_ex)));

    always_comb begin
        Forward1 = 2'b00;
        Forward2 = 2'b00;
        if (!reset) begin
            if (rs1_used(op_ex)) begin
                if (prod_hit(regFileWe_MEM, rd_mem, rs1_ex))
                    Forward1 = 2'b01;
                else if (NUM_FWD == 2 && prod_hit(regFileWe_WB, rd_wb, rs1_ex))
                    Forward1 = 2'b10;
            end
            if (rs2_used(op_ex)) begin
                if (prod_hit(regFileWe_MEM, rd_mem, rs2_ex))
                    Forward2 = 2'b01;
                else if (NUM_FWD == 2 && prod_hit(regFileWe_WB, rd_wb, rs2_ex))
                    Forward2 = 2'b10;
            end
        end
    end

    logic idle_path;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCEn       = 1'b1;
        stall      = 1'b0;
        hold_EXE   = 1'b0;
        bubble_EXE = 1'b0;
        flush_IF   = 1'b0;
        flush_ID   = 1'b0;
        idle_path  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mdu_start && !mdu_done) begin
                    state_d  = MDU_BUSY;
                    stall    = 1'b1;
                    PCEn     = 1'b0;
                    hold_EXE = 1'b1;
                end else begin
                    idle_path = 1'b1;
                end
            end
            LOAD_STALL: begin
                stall      = 1'b1;
                PCEn       = 1'b0;
                bubble_EXE = 1'b1;
                if (cnt_q == 3'd0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            MDU_BUSY: begin
                // The done cycle releases the pipeline and is judged like an ordinary IDLE cycle.
                if (mdu_done) begin
                    state_d   = IDLE;
                    idle_path = 1'b1;
                end else begin
                    stall    = 1'b1;
                    PCEn     = 1'b0;
                    hold_EXE = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (idle_path) begin
            if (PC_SrcMuxSel) begin
                flush_IF = 1'b1;
                flush_ID = 1'b1;
            end else if (ld_use) begin
                stall      = 1'b1;
                PCEn       = 1'b0;
                bubble_EXE = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LOAD_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
        end

        if (reset) begin
            PCEn       = 1'b1;
            stall      = 1'b0;
            hold_EXE   = 1'b0;
            bubble_EXE = 1'b0;
            flush_IF   = 1'b0;
            flush_ID   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state = reset ? IDLE : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset)
            perf_q <= 32'd0;
        else if (stall)
            perf_q <= perf_q + 32'd1;
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed and randomized bench for hazard_ctrl_unit against a cycle model
module tb_hazard_ctrl_unit;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
    localparam logic [6:0] RTYPE = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, we_mem, we_wb, br, ms, md;
    logic [31:0] iid, iex, imem, iwb;

    logic [1:0]  f1 [2];
    logic [1:0]  f2 [2];
    logic        pcen [2];
    logic        stl [2];
    logic        hold [2];
    logic        bub [2];
    logic        fif [2];
    logic        fid [2];
    logic [1:0]  hz [2];
    logic [31:0] sc [2];

    hazard_ctrl_unit #(.LOAD_LAT(3), .NUM_FWD(2)) dut (
        .clk(clk), .reset(reset), .instrCode_ID(iid), .instrCode_EXE(iex),
        .instrCode_MEM(imem), .instrCode_WB(iwb), .regFileWe_MEM(we_mem),
        .regFileWe_WB(we_wb), .PC_SrcMuxSel(br), .mdu_start(ms), .mdu_done(md),
        .Forward1(f1[0]), .Forward2(f2[0]), .PCEn(pcen[0]), .stall(stl[0]),
        .hold_EXE(hold[0]), .bubble_EXE(bub[0]), .flush_IF(fif[0]), .flush_ID(fid[0]),
        .hz_state(hz[0]), .stall_cycles(sc[0])
    );

    hazard_ctrl_unit #(.LOAD_LAT(4), .NUM_FWD(1)) dut_b (
        .clk(clk), .reset(reset), .instrCode_ID(iid), .instrCode_EXE(iex),
        .instrCode_MEM(imem), .instrCode_WB(iwb), .regFileWe_MEM(we_mem),
        .regFileWe_WB(we_wb), .PC_SrcMuxSel(br), .mdu_start(ms), .mdu_done(md),
        .Forward1(f1[1]), .Forward2(f2[1]), .PCEn(pcen[1]), .stall(stl[1]),
        .hold_EXE(hold[1]), .bubble_EXE(bub[1]), .flush_IF(fif[1]), .flush_ID(fid[1]),
        .hz_state(hz[1]), .stall_cycles(sc[1])
    );

    int checks = 0;
    int errors = 0;

    // Model state: remaining load-stall cycles after the current one, MDU busy flag, stall count.
    int          lat [2]  = '{3, 4};
    int          nfwd [2] = '{2, 1};
    int          left [2] = '{0, 0};
    bit          busy [2] = '{0, 0};
    logic [31:0] perf [2] = '{32'd0, 32'd0};

    function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    function automatic logic r1u(logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic r2u(logic [6:0] op);
        return op == RTYPE || op == STORE || op == BRANCH;
    endfunction

    function automatic logic [1:0] exp_fwd(int n, logic [4:0] rs, logic used);
        if (!used) return 2'b00;
        if (we_mem && imem[11:7] != 0 && imem[11:7] == rs) return 2'b01;
        if (n == 2 && we_wb && iwb[11:7] != 0 && iwb[11:7] == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model for the current inputs, then advance the model.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            logic e_pcen, e_stall, e_hold, e_bub, e_fl, ldu;
            logic [1:0] e_hz, e_f1, e_f2;
            logic [31:0] e_sc;
            e_pcen = 1; e_stall = 0; e_hold = 0; e_bub = 0; e_fl = 0; e_hz = 0;
            ldu = iex[6:0] == LOAD && iex[11:7] != 0 &&
                  ((r1u(iid[6:0]) && iid[19:15] == iex[11:7]) ||
                   (r2u(iid[6:0]) && iid[24:20] == iex[11:7]));
            if (!reset) begin
                e_hz = busy[k] ? 2'b10 : (left[k] > 0 ? 2'b01 : 2'b00);
                if ((busy[k] && !md) || (!busy[k] && left[k] == 0 && ms && !md)) begin
                    e_pcen = 0; e_stall = 1; e_hold = 1;
                end else if (left[k] > 0) begin
                    e_pcen = 0; e_stall = 1; e_bub = 1;
                end else if (br) begin
                    e_fl = 1;
                end else if (ldu) begin
                    e_pcen = 0; e_stall = 1; e_bub = 1;
                end
            end
            e_f1 = reset ? 2'b00 : exp_fwd(nfwd[k], iex[19:15], r1u(iex[6:0]));
            e_f2 = reset ? 2'b00 : exp_fwd(nfwd[k], iex[24:20], r2u(iex[6:0]));
`ifdef HAZARD_PERF_CNT_EN
            e_sc = perf[k];
`else
            e_sc = 32'd0;
`endif
            check($sformatf("d%0d Forward1", k), f1[k], e_f1);
            check($sformatf("d%0d Forward2", k), f2[k], e_f2);
            check($sformatf("d%0d PCEn", k), pcen[k], e_pcen);
            check($sformatf("d%0d stall", k), stl[k], e_stall);
            check($sformatf("d%0d hold_EXE", k), hold[k], e_hold);
            check($sformatf("d%0d bubble_EXE", k), bub[k], e_bub);
            check($sformatf("d%0d flush", k), {fif[k], fid[k]}, {e_fl, e_fl});
            check($sformatf("d%0d hz_state", k), hz[k], e_hz);
            if (!reset) check($sformatf("d%0d stall_cycles", k), sc[k], e_sc);

            if (reset) begin
                left[k] = 0; busy[k] = 0; perf[k] = 0;
            end else begin
                perf[k] = perf[k] + 32'(e_stall);
                if (busy[k]) begin
                    if (md) begin
                        busy[k] = 0;
                        if (!br && ldu && lat[k] > 1) left[k] = lat[k] - 1;
                    end
                end else if (left[k] > 0) begin
                    left[k]--;
                end else if (ms && !md) begin
                    busy[k] = 1;
                end else if (!br && ldu && lat[k] > 1) begin
                    left[k] = lat[k] - 1;
                end
            end
        end
    endtask

    task automatic tick();
        step();
        @(negedge clk);
    endtask

    task automatic nops(int n);
        iid = enc(OPIMM, 0, 0, 0); iex = iid; imem = iid; iwb = iid;
        we_mem = 0; we_wb = 0; br = 0; ms = 0; md = 0;
        for (int i = 0; i < n; i++) begin
            #1; tick();
        end
    endtask

    logic [6:0] ops [9] = '{LOAD, STORE, BRANCH, RTYPE, OPIMM, LUI, AUIPC, JAL, JALR};

    function automatic logic [31:0] rnd_instr();
        return enc(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    initial begin
        logic [31:0] lw5, add6;
        bit idle;
        lw5  = enc(LOAD, 5, 1, 0);
        add6 = enc(RTYPE, 6, 5, 2);

        @(negedge clk);
        reset = 1;
        nops(1);
        #1;
        check("reset PCEn", pcen[0], 1'b1);
        check("reset stall", stl[0], 1'b0);
        check("reset hz_state", hz[0], 2'b00);
        tick();
        reset = 0;
        nops(2);

        // lw x5 in EXE, add x6,x5,x2 in ID: three stall cycles on the LOAD_LAT=3 instance
        iex = lw5; iid = add6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lduse stall", stl[0], 1'b1);
            check("lduse bubble", bub[0], 1'b1);
            check("lduse hz_state", hz[0], (i == 0) ? 2'b00 : 2'b01);
            tick();
        end
        iex = add6; imem = lw5; we_mem = 1; iid = enc(OPIMM, 0, 0, 0);
        #1;
        check("lduse release stall", stl[0], 1'b0);
        check("lduse release hz", hz[0], 2'b00);
        check("lduse fwd from MEM", f1[0], 2'b01);
        tick();
        nops(5);

        // MEM/WB both produce x3; MEM wins, then WB-only depends on NUM_FWD
        imem = enc(RTYPE, 3, 1, 2); we_mem = 1;
        iwb = enc(RTYPE, 3, 4, 5); we_wb = 1;
        iex = enc(RTYPE, 4, 3, 3);
        #1;
        check("fwd MEM prio F1", f1[0], 2'b01);
        check("fwd MEM prio F2", f2[0], 2'b01);
        tick();
        we_mem = 0;
        #1;
        check("fwd WB nfwd2", f1[0], 2'b10);
        check("fwd WB nfwd1", f1[1], 2'b00);
        tick();

        imem = enc(RTYPE, 0, 1, 2); we_mem = 1; we_wb = 0; iex = enc(RTYPE, 4, 0, 0);
        #1;
        check("fwd x0", {f1[0], f2[0]}, 4'b0000);
        tick();
        nops(1);
        iex = lw5; iid = enc(LUI, 5, 5, 5);
        #1;
        check("lui no stall", stl[0], 1'b0);
        tick();
        nops(1);

        // Branch in the load-use detect cycle flushes instead of stalling
        iex = lw5; iid = add6; br = 1;
        #1;
        check("branch flush_IF", fif[0], 1'b1);
        check("branch flush_ID", fid[0], 1'b1);
        check("branch no stall", stl[0], 1'b0);
        tick();
        nops(1);
        check("branch hz after", hz[0], 2'b00);
        nops(2);

        // MDU busy for 10 cycles after a fresh reset
        reset = 1;
        nops(1);
        reset = 0;
        ms = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("mdu stall", stl[0], 1'b1);
            check("mdu hold", hold[0], 1'b1);
            tick();
            ms = 0;
        end
        md = 1;
        #1;
        check("mdu done release", stl[0], 1'b0);
        check("mdu done PCEn", pcen[0], 1'b1);
        tick();
        md = 0;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("mdu stall_cycles", sc[0], 32'd10);
`else
        check("mdu stall_cycles", sc[0], 32'd0);
`endif
        tick();
        nops(2);

        // Reset in the second cycle of a LOAD_LAT=4 stall
        iex = lw5; iid = add6;
        #1; tick();
        reset = 1;
        #1;
        check("rst mid hz before", hz[1], 2'b00);
        tick();
        reset = 0;
        nops(0);
        #1;
        check("rst mid stall", stl[1], 1'b0);
        check("rst mid PCEn", pcen[1], 1'b1);
        check("rst mid hz", hz[1], 2'b00);
        check("rst mid stall_cycles", sc[1], 32'd0);
        tick();
        nops(2);

        for (int n = 0; n < 600; n++) begin
            idle = !busy[0] && !busy[1] && left[0] == 0 && left[1] == 0;
            iid = rnd_instr(); iex = rnd_instr(); imem = rnd_instr(); iwb = rnd_instr();
            we_mem = 1'($urandom_range(0, 1));
            we_wb  = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 49) == 0);
            br     = idle && ($urandom_range(0, 5) == 0);
            ms     = idle && ($urandom_range(0, 9) == 0);
            md     = (busy[0] || busy[1]) && ($urandom_range(0, 5) == 0);
            #1; tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
